// File: rtl/exp_core_arbiter_if.sv
// Signal bundle joining the requester ports, the arbiter and the shared exponent core.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface exp_core_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_base;
    logic [NREQ*WIDTH-1:0] req_exp;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_error;
    logic [NREQ-1:0]       rsp_ready;
    logic                  core_start;
    logic [WIDTH-1:0]      core_x;
    logic [WIDTH-1:0]      core_a;
    logic                  core_done;
    logic [WIDTH-1:0]      core_p;
    logic                  busy;

    modport master (
        input  req_valid, req_base, req_exp, rsp_ready, core_done, core_p,
        output req_ready, rsp_valid, rsp_result, rsp_error, core_start, core_x, core_a, busy
    );

    modport slave (
        output req_valid, req_base, req_exp, rsp_ready, core_done, core_p,
        input  req_ready, rsp_valid, rsp_result, rsp_error, core_start, core_x, core_a, busy
    );
endinterface

// File: rtl/exp_core_arbiter.sv
// Round-robin arbiter that shares one iterative exponent core among NREQ requesters,
// with a timeout on the core and valid/ready backpressure on the returned result.
module exp_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    exp_core_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    idx;
    logic             pick_found;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] result_q;
    logic             error_q;
    logic             timed_out;

    // Walk downward so the candidate closest to rr_ptr is the last one written and wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    assign timed_out = (count == CW'(TIMEOUT - 1));

    always_comb begin
        state_next     = state;
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.core_start = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    bus.req_ready[pick] = 1'b1;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                bus.core_start = 1'b1;
                state_next     = WAIT;
            end
            WAIT: begin
                if (bus.core_done || timed_out) state_next = RESPOND;
            end
            RESPOND: begin
                bus.rsp_valid[grant] = 1'b1;
                if (bus.rsp_ready[grant]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy       = (state != IDLE);
    assign bus.core_x     = x_q;
    assign bus.core_a     = a_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = error_q;

    // A core_done outside WAIT falls through every branch below and is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            count    <= '0;
            x_q      <= '0;
            a_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick;
                        x_q   <= bus.req_base[int'(pick) * WIDTH +: WIDTH];
                        a_q   <= bus.req_exp[int'(pick) * WIDTH +: WIDTH];
                    end
                end
                ISSUE: begin
                    count <= '0;
                end
                WAIT: begin
                    count <= count + 1'b1;
                    if (bus.core_done) begin
                        result_q <= bus.core_p;
                        error_q  <= 1'b0;
                    end else if (timed_out) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready[grant]) begin
                        rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_core_arbiter.sv
// Self-checking bench for exp_core_arbiter: directed scenarios plus randomized traffic
// checked against a request-level round-robin and exponent model.
module tb_exp_core_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic clock;
    logic reset;
    int   checks;
    int   passes;
    int   rr_model;
    int   core_lat;
    logic core_armed;
    int   core_cnt;
    logic [31:0] core_res;

    exp_core_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    exp_core_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] pow32(input logic [31:0] b, input logic [31:0] e);
        logic [31:0] r;
        logic [31:0] p;
        r = 32'd1;
        p = b;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = r * p;
            p = p * p;
        end
        return r;
    endfunction

    // Requester that has just been served goes to the back of the line.
    function automatic int model_pick(input logic [3:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(rr_model + k) % NREQ]) return (rr_model + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural core: answers lat cycles after the start pulse, never when lat is 0.
    initial begin
        core_armed    = 1'b0;
        core_cnt      = 0;
        core_res      = '0;
        bus.core_done = 1'b0;
        bus.core_p    = '0;
        forever begin
            @(negedge clock);
            bus.core_done = 1'b0;
            bus.core_p    = $urandom;
            if (core_armed) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.core_done = 1'b1;
                    bus.core_p    = core_res;
                    core_armed    = 1'b0;
                end
            end
            if (bus.core_start === 1'b1) begin
                core_armed = (core_lat > 0);
                core_cnt   = core_lat;
                core_res   = pow32(bus.core_x, bus.core_a);
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] b, input logic [31:0] e);
        bus.req_base[i*WIDTH +: WIDTH] = b;
        bus.req_exp[i*WIDTH +: WIDTH]  = e;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        @(negedge clock);
        reset    = 1'b0;
        rr_model = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.req_ready == '0 && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (bus.req_ready == '0) n = -1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < 80) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (bus.rsp_valid == '0) n = -1;
    endtask

    task automatic release_rsp(input logic [3:0] r);
        bus.rsp_ready = r;
        @(negedge clock);
        bus.rsp_ready = '0;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error,
             bus.core_start, bus.core_x, bus.core_a} !== '0)
            $display("[TB] FAIL reset_outputs: got ready=%b valid=%b result=%h err=%b start=%b x=%h a=%h expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error,
                     bus.core_start, bus.core_x, bus.core_a);
        else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        else passes++;
    endtask

    task automatic test_single();
        int n;
        @(negedge clock);
        set_op(0, 32'd3, 32'd4);
        core_lat      = 5;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) $display("[TB] FAIL single_ready: got %b expected 0001", bus.req_ready);
        else passes++;
        @(negedge clock);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.core_start !== 1'b1 || bus.core_x !== 32'd3 || bus.core_a !== 32'd4)
            $display("[TB] FAIL single_start: got start=%b x=%0d a=%0d expected 1/3/4",
                     bus.core_start, bus.core_x, bus.core_a);
        else passes++;
        wait_rsp(n);
        checks++;
        if (n != 6) $display("[TB] FAIL single_latency: got %0d cycles expected 6", n);
        else passes++;
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_result !== 32'd81 || bus.rsp_error !== 1'b0)
            $display("[TB] FAIL single_rsp: got valid=%b result=%0d err=%b expected 0001/81/0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_error);
        else passes++;
        release_rsp(4'b0001);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000)
            $display("[TB] FAIL single_idle: got busy=%b valid=%b expected 0/0000", bus.busy, bus.rsp_valid);
        else passes++;
        rr_model = 1;
    endtask

    task automatic test_all_four();
        int n;
        logic [3:0] pending;
        do_reset();
        core_lat = 3;
        @(negedge clock);
        for (int i = 0; i < NREQ; i++) set_op(i, 32'd2, 32'(i + 1));
        pending       = 4'b1111;
        bus.req_valid = pending;
        bus.rsp_ready = 4'b1111;
        #1;
        for (int t = 0; t < NREQ; t++) begin
            wait_ready(n);
            checks++;
            if (n < 0 || bus.req_ready !== 4'(1 << t))
                $display("[TB] FAIL all4_grant: got %b expected %b", bus.req_ready, 4'(1 << t));
            else passes++;
            pending[t] = 1'b0;
            @(negedge clock);
            bus.req_valid = pending;
            #1;
            wait_rsp(n);
            checks++;
            if (n < 0 || bus.rsp_valid !== 4'(1 << t) || bus.rsp_result !== (32'd1 << (t + 1)) ||
                bus.rsp_error !== 1'b0)
                $display("[TB] FAIL all4_rsp: got valid=%b result=%0d err=%b expected %b/%0d/0",
                         bus.rsp_valid, bus.rsp_result, bus.rsp_error, 4'(1 << t), 32'd1 << (t + 1));
            else passes++;
            rr_model = (t + 1) % NREQ;
            @(negedge clock);
            #1;
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic test_fairness();
        int n;
        int g;
        int prev;
        logic [31:0] b[4];
        logic [31:0] e[4];
        prev     = -1;
        core_lat = 2;
        @(negedge clock);
        for (int i = 0; i < NREQ; i++) begin
            b[i] = $urandom;
            e[i] = 32'($urandom_range(0, 20));
            set_op(i, b[i], e[i]);
        end
        bus.req_valid = 4'b0101;
        bus.rsp_ready = 4'b1111;
        #1;
        for (int t = 0; t < 4; t++) begin
            g = model_pick(4'b0101);
            wait_ready(n);
            checks++;
            if (n < 0 || bus.req_ready !== 4'(1 << g))
                $display("[TB] FAIL fair_grant: got %b expected %b", bus.req_ready, 4'(1 << g));
            else passes++;
            checks++;
            if (bus.req_ready === 4'(1 << prev) && prev >= 0)
                $display("[TB] FAIL fair_repeat: got %b expected a different requester than %0d",
                         bus.req_ready, prev);
            else passes++;
            prev = g;
            @(negedge clock);
            #1;
            wait_rsp(n);
            checks++;
            if (n < 0 || bus.rsp_valid !== 4'(1 << g) || bus.rsp_result !== pow32(b[g], e[g]))
                $display("[TB] FAIL fair_rsp: got valid=%b result=%h expected %b/%h",
                         bus.rsp_valid, bus.rsp_result, 4'(1 << g), pow32(b[g], e[g]));
            else passes++;
            rr_model = (g + 1) % NREQ;
            @(negedge clock);
            #1;
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] expected;
        logic bad;
        @(negedge clock);
        set_op(1, 32'd7, 32'd5);
        core_lat      = 4;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = '0;
        #1;
        wait_ready(n);
        checks++;
        if (n < 0 || bus.req_ready !== 4'b0010) $display("[TB] FAIL bp_grant: got %b expected 0010", bus.req_ready);
        else passes++;
        @(negedge clock);
        bus.req_valid = 4'b0101;
        bus.rsp_ready = 4'b1101;
        #1;
        wait_rsp(n);
        expected = 32'd16807;
        checks++;
        if (n < 0 || bus.rsp_valid !== 4'b0010 || bus.rsp_result !== expected)
            $display("[TB] FAIL bp_rsp: got valid=%b result=%0d expected 0010/%0d", bus.rsp_valid, bus.rsp_result, expected);
        else passes++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            #1;
            bad = (bus.rsp_valid !== 4'b0010) || (bus.rsp_result !== expected) ||
                  (bus.rsp_error !== 1'b0) || (bus.req_ready !== 4'b0000) || (bus.busy !== 1'b1);
            checks++;
            if (bad)
                $display("[TB] FAIL bp_hold: cycle %0d got valid=%b result=%0d ready=%b busy=%b expected 0010/%0d/0000/1",
                         c, bus.rsp_valid, bus.rsp_result, bus.req_ready, bus.busy, expected);
            else passes++;
        end
        @(negedge clock);
        bus.req_valid = '0;
        release_rsp(4'b0010);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000)
            $display("[TB] FAIL bp_release: got busy=%b valid=%b expected 0/0000", bus.busy, bus.rsp_valid);
        else passes++;
        rr_model = 2;
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clock);
        set_op(3, 32'd5, 32'd3);
        core_lat      = 0;
        bus.req_valid = 4'b1000;
        #1;
        wait_ready(n);
        checks++;
        if (n < 0 || bus.req_ready !== 4'b1000) $display("[TB] FAIL to_grant: got %b expected 1000", bus.req_ready);
        else passes++;
        @(negedge clock);
        bus.req_valid = '0;
        #1;
        wait_rsp(n);
        checks++;
        if (n != TIMEOUT + 1) $display("[TB] FAIL to_latency: got %0d cycles expected %0d", n, TIMEOUT + 1);
        else passes++;
        checks++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_error !== 1'b1 || bus.rsp_result !== 32'd0)
            $display("[TB] FAIL to_rsp: got valid=%b err=%b result=%h expected 1000/1/0",
                     bus.rsp_valid, bus.rsp_error, bus.rsp_result);
        else passes++;
        release_rsp(4'b1000);
        rr_model = 0;
    endtask

    task automatic test_coincident();
        int n;
        @(negedge clock);
        set_op(0, 32'd5, 32'd3);
        core_lat      = TIMEOUT;
        bus.req_valid = 4'b0001;
        #1;
        wait_ready(n);
        @(negedge clock);
        bus.req_valid = '0;
        #1;
        wait_rsp(n);
        checks++;
        if (n != TIMEOUT + 1 || bus.rsp_valid !== 4'b0001 || bus.rsp_error !== 1'b0 || bus.rsp_result !== 32'd125)
            $display("[TB] FAIL coincident: got n=%0d valid=%b err=%b result=%0d expected %0d/0001/0/125",
                     n, bus.rsp_valid, bus.rsp_error, bus.rsp_result, TIMEOUT + 1);
        else passes++;
        release_rsp(4'b0001);
        rr_model = 1;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int order[2];
        logic bad;
        logic [3:0] pending;
        order[0] = 1;
        order[1] = 3;
        @(negedge clock);
        set_op(2, 32'd9, 32'd2);
        core_lat      = 8;
        bus.req_valid = 4'b0100;
        #1;
        wait_ready(n);
        @(negedge clock);
        bus.req_valid = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.core_start,
             bus.core_x, bus.core_a, bus.busy} !== '0)
            $display("[TB] FAIL midreset_outputs: got ready=%b valid=%b result=%h err=%b start=%b x=%h a=%h busy=%b expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.core_start,
                     bus.core_x, bus.core_a, bus.busy);
        else passes++;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            #1;
            if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) $display("[TB] FAIL midreset_late_done: got busy=%b valid=%b expected 0/0000", bus.busy, bus.rsp_valid);
        else passes++;
        rr_model = 0;
        core_lat = 2;
        @(negedge clock);
        set_op(1, 32'd3, 32'd3);
        set_op(3, 32'd2, 32'd10);
        pending       = 4'b1010;
        bus.req_valid = pending;
        bus.rsp_ready = 4'b1111;
        #1;
        for (int t = 0; t < 2; t++) begin
            wait_ready(n);
            checks++;
            if (n < 0 || bus.req_ready !== 4'(1 << order[t]))
                $display("[TB] FAIL midreset_grant: got %b expected %b", bus.req_ready, 4'(1 << order[t]));
            else passes++;
            pending[order[t]] = 1'b0;
            @(negedge clock);
            bus.req_valid = pending;
            #1;
            wait_rsp(n);
            @(negedge clock);
            #1;
        end
        rr_model      = 0;
        bus.rsp_ready = '0;
    endtask

    task automatic test_random();
        int n;
        int g;
        int lat;
        int exp_n;
        logic [3:0] mask;
        logic [31:0] b[4];
        logic [31:0] e[4];
        logic [31:0] exp_res;
        logic exp_err;
        for (int t = 0; t < 30; t++) begin
            mask = 4'($urandom_range(1, 15));
            lat  = $urandom_range(1, TIMEOUT + 2);
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) begin
                b[i] = $urandom;
                e[i] = 32'($urandom_range(0, 40));
                set_op(i, b[i], e[i]);
            end
            core_lat      = lat;
            bus.req_valid = mask;
            bus.rsp_ready = '0;
            #1;
            g = model_pick(mask);
            wait_ready(n);
            checks++;
            if (n < 0 || bus.req_ready !== 4'(1 << g))
                $display("[TB] FAIL rand_grant: txn %0d got %b expected %b", t, bus.req_ready, 4'(1 << g));
            else passes++;
            @(negedge clock);
            bus.req_valid = 4'($urandom);
            #1;
            checks++;
            if (bus.core_start !== 1'b1 || bus.core_x !== b[g] || bus.core_a !== e[g])
                $display("[TB] FAIL rand_operands: txn %0d got start=%b x=%h a=%h expected 1/%h/%h",
                         t, bus.core_start, bus.core_x, bus.core_a, b[g], e[g]);
            else passes++;
            wait_rsp(n);
            exp_err = (lat > TIMEOUT);
            exp_res = exp_err ? 32'd0 : pow32(b[g], e[g]);
            exp_n   = exp_err ? TIMEOUT + 1 : lat + 1;
            checks++;
            if (n != exp_n || bus.rsp_valid !== 4'(1 << g) || bus.rsp_result !== exp_res || bus.rsp_error !== exp_err)
                $display("[TB] FAIL rand_rsp: txn %0d got n=%0d valid=%b result=%h err=%b expected %0d/%b/%h/%b",
                         t, n, bus.rsp_valid, bus.rsp_result, bus.rsp_error, exp_n, 4'(1 << g), exp_res, exp_err);
            else passes++;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                bus.rsp_ready = 4'($urandom) & ~4'(1 << g);
                #1;
            end
            @(negedge clock);
            bus.req_valid = '0;
            release_rsp(4'(1 << g));
            checks++;
            if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000)
                $display("[TB] FAIL rand_release: txn %0d got busy=%b valid=%b expected 0/0000", t, bus.busy, bus.rsp_valid);
            else passes++;
            rr_model = (g + 1) % NREQ;
        end
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        rr_model      = 0;
        core_lat      = 0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_base  = '0;
        bus.req_exp   = '0;
        bus.rsp_ready = '0;
        repeat (3) @(negedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        test_single();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_coincident();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
